// File: rtl/dht_pkg.sv
// Shared constants and types for the DHT11 UART reporter: frame layout, STATUS bit positions, FSM states.
package dht_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hAA;
  localparam int FRAME_LEN = 7;

  localparam int ST_SENSOR_ERR = 0;
  localparam int ST_CRC_ERR    = 1;
  localparam int ST_OVERRUN    = 2;

  typedef enum logic [2:0] {IDLE, CAPTURE, LOAD, SHIFT, DONE} state_t;

  typedef struct packed {
    logic [7:0] hum_int;
    logic [7:0] hum_float;
    logic [7:0] temp_int;
    logic [7:0] temp_float;
  } reading_t;

  function automatic logic [7:0] sum4(input reading_t r);
    return r.hum_int + r.hum_float + r.temp_int + r.temp_float;
  endfunction

endpackage

// File: rtl/dht11_uart_reporter_uart_tx.sv
// UART 8N1 transmitter: start accepted only when idle, tx drops low the cycle after start.
// done pulses during the last cycle of the stop bit so a new byte can follow after one idle cycle.
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     st;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign done    = (st == TX_STOP) && bit_end;

  always_ff @(posedge CLK) begin
    if (RST) begin
      st       <= TX_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (st)
        TX_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (start) begin
            st    <= TX_START;
            tx    <= 1'b0;
            shreg <= data;
          end
        end
        TX_START: if (bit_end) begin
          st      <= TX_DATA;
          tx      <= shreg[0];
          bit_idx <= '0;
        end
        TX_DATA: if (bit_end) begin
          if (bit_idx == 4'd7) begin
            st <= TX_STOP;
            tx <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            tx      <= shreg[1];
            shreg   <= shreg >> 1;
          end
        end
        TX_STOP: if (bit_end) st <= TX_IDLE;
        default: st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dht11_uart_reporter.sv
// On each SENSOR_WAIT fall, snapshot the DHT11 reading and send AA,STATUS,HI,HF,TI,TF,FCS over UART 8N1.
// Start bit 3 cycles after the edge; edges during a frame set the overrun flag, never queue. DHT_CRC_CHECK_EN builds the checksum check.
module dht11_uart_reporter
  import dht_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SENSOR_WAIT,
  input  logic       SENSOR_ERR,
  input  logic [7:0] HUM_INT,
  input  logic [7:0] HUM_FLOAT,
  input  logic [7:0] TEMP_INT,
  input  logic [7:0] TEMP_FLOAT,
  input  logic [7:0] CRC,
  output logic       TX,
  output logic       BUSY,
  output logic       FRAME_SENT
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  state_t     state;
  logic       wait_q;
  logic       overrun;
  logic [2:0] idx;
  logic [7:0] frame [FRAME_LEN];
  logic       start_cond;
  logic       tx_done;
  reading_t   raw;
  reading_t   rd;
  logic       crc_bad;
  logic [7:0] status;
  logic [7:0] fcs;

  assign start_cond = wait_q & ~SENSOR_WAIT;
  assign raw        = {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT};
  assign rd         = SENSOR_ERR ? '0 : raw;

`ifdef DHT_CRC_CHECK_EN
  assign crc_bad = ~SENSOR_ERR & (sum4(raw) != CRC);
`else
  logic unused_crc;
  assign unused_crc = ^CRC;
  assign crc_bad    = 1'b0;
`endif

  always_comb begin
    status                = '0;
    status[ST_SENSOR_ERR] = SENSOR_ERR;
    status[ST_CRC_ERR]    = crc_bad;
    status[ST_OVERRUN]    = overrun;
  end

  assign fcs = status + sum4(rd);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      idx        <= '0;
      overrun    <= 1'b0;
      wait_q     <= 1'b1;
      BUSY       <= 1'b0;
      FRAME_SENT <= 1'b0;
    end else begin
      wait_q     <= SENSOR_WAIT;
      FRAME_SENT <= 1'b0;
      case (state)
        IDLE: if (start_cond) begin
          state <= CAPTURE;
          BUSY  <= 1'b1;
        end
        CAPTURE: begin
          frame[0] <= FRAME_HDR;
          frame[1] <= status;
          frame[2] <= rd.hum_int;
          frame[3] <= rd.hum_float;
          frame[4] <= rd.temp_int;
          frame[5] <= rd.temp_float;
          frame[6] <= fcs;
          overrun  <= 1'b0;
          idx      <= '0;
          state    <= LOAD;
        end
        LOAD: state <= SHIFT;
        SHIFT: if (tx_done) begin
          if (idx < LAST_IDX) begin
            idx   <= idx + 3'd1;
            state <= LOAD;
          end else begin
            state      <= DONE;
            FRAME_SENT <= 1'b1;
          end
        end
        DONE: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Edges outside IDLE (including the DONE cycle) are dropped but remembered for the next STATUS.
      if (start_cond && state != IDLE) overrun <= 1'b1;
    end
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .CLK   (CLK),
    .RST   (RST),
    .start (state == LOAD),
    .data  (frame[idx]),
    .tx    (TX),
    .done  (tx_done)
  );

endmodule
